mac_load_sequencer: RTL and testbench

MAC_LOAD_SEQUENCER -- requirements
Module: mac_load_sequencer

---
 rtl/mac_load_sequencer.sv | 117 +++++++++++
 tb/tb_mac_load_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_load_sequencer.sv
// Load sequencer: streams feature/weight bytes into the MAC loader,
// then launches the MAC and reports job completion.
module mac_load_sequencer #(
    parameter int N_A = 16,
    parameter int N_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             a_valid,
    input  logic signed [7:0] a_data,
    output logic             a_ready,
    input  logic             w_valid,
    input  logic signed [7:0] w_data,
    output logic             w_ready,
    input  logic             mac_done,
    output logic             loader_rst,
    output logic signed [7:0] port_A,
    output logic             write_enable_A,
    output logic signed [7:0] port_W,
    output logic             write_enable_W,
    output logic             mac_start,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, FIRE, WAIT, DONE
    } state_t;

    localparam logic [4:0] NA = 5'(N_A);
    localparam logic [4:0] NW = 5'(N_W);

    state_t            state_q, state_d;
    logic [4:0]        cnt_a_q, cnt_a_d;
    logic [4:0]        cnt_w_q, cnt_w_d;
    logic signed [7:0] port_a_q, port_a_d;
    logic signed [7:0] port_w_q, port_w_d;
    logic              we_a_q, we_a_d;
    logic              we_w_q, we_w_d;
    logic              a_hs, w_hs;

    // Ready drops with abort so an aborted cycle never launches a write
    assign a_ready = (state_q == LOAD) && (cnt_a_q < NA) && !abort;
    assign w_ready = (state_q == LOAD) && (cnt_w_q < NW) && !abort;
    assign a_hs    = a_valid && a_ready;
    assign w_hs    = w_valid && w_ready;

    always_comb begin
        state_d  = state_q;
        cnt_a_d  = cnt_a_q;
        cnt_w_d  = cnt_w_q;
        port_a_d = port_a_q;
        port_w_d = port_w_q;
        we_a_d   = 1'b0;
        we_w_d   = 1'b0;

        if (a_hs) begin
            port_a_d = a_data;
            we_a_d   = 1'b1;
            cnt_a_d  = cnt_a_q + 5'd1;
        end
        if (w_hs) begin
            port_w_d = w_data;
            we_w_d   = 1'b1;
            cnt_w_d  = cnt_w_q + 5'd1;
        end

        unique case (state_q)
            IDLE:  if (start) state_d = CLEAR;
            CLEAR: begin
                cnt_a_d = 5'd0;
                cnt_w_d = 5'd0;
                state_d = LOAD;
            end
            // Full counts mean the last strobe is already on the port
            LOAD:  if (cnt_a_q == NA && cnt_w_q == NW) state_d = FIRE;
            FIRE:  state_d = WAIT;
            WAIT:  if (mac_done) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_a_q  <= 5'd0;
            cnt_w_q  <= 5'd0;
            port_a_q <= 8'sd0;
            port_w_q <= 8'sd0;
            we_a_q   <= 1'b0;
            we_w_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_a_q  <= cnt_a_d;
            cnt_w_q  <= cnt_w_d;
            port_a_q <= port_a_d;
            port_w_q <= port_w_d;
            we_a_q   <= we_a_d;
            we_w_q   <= we_w_d;
        end
    end

    assign port_A         = port_a_q;
    assign port_W         = port_w_q;
    assign write_enable_A = we_a_q;
    assign write_enable_W = we_w_q;
    assign loader_rst     = (state_q == CLEAR);
    assign mac_start      = (state_q == FIRE);
    assign done           = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mac_load_sequencer.sv
// Directed bench for mac_load_sequencer: nominal, skewed, overrun,
// abort, reset-in-WAIT and ignored-input scenarios.
module tb_mac_load_sequencer;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic              a_valid, w_valid, mac_done;
    logic signed [7:0] a_data, w_data;
    logic              a_ready, w_ready, loader_rst;
    logic signed [7:0] port_A, port_W;
    logic              write_enable_A, write_enable_W;
    logic              mac_start, busy, done;

    int pass_cnt = 0;
    int total    = 0;
    int n_wa, n_ww, n_ms, n_done, n_lr;

    mac_load_sequencer #(.N_A(16), .N_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .mac_done(mac_done), .loader_rst(loader_rst),
        .port_A(port_A), .write_enable_A(write_enable_A),
        .port_W(port_W), .write_enable_W(write_enable_W),
        .mac_start(mac_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (write_enable_A) n_wa++;
            if (write_enable_W) n_ww++;
            if (mac_start)      n_ms++;
            if (done)           n_done++;
            if (loader_rst)     n_lr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_wa = 0; n_ww = 0; n_ms = 0; n_done = 0; n_lr = 0;
    endtask

    // start pulse, then CLEAR cycle; leaves the DUT in its first LOAD cycle
    task automatic begin_job();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clear_loader_rst", {31'd0, loader_rst}, 32'd1);
        step();
        chk("load_loader_rst", {31'd0, loader_rst}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mac_done = 1'b0;
        a_valid = 1'b0; w_valid = 1'b0; a_data = '0; w_data = '0;
        clr_mon();
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {24'd0, loader_rst, write_enable_A, write_enable_W,
            mac_start, done, a_ready, w_ready, busy}, 32'd0);
        chk("rst_ports", {16'd0, port_A, port_W}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Nominal job
        clr_mon();
        begin_job();
        chk("nom_ready", {30'd0, a_ready, w_ready}, 32'd3);
        a_valid = 1'b1; w_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_data = 8'(i + 1); w_data = 8'(i + 1);
            step();
            chk("nom_we", {30'd0, write_enable_A, write_enable_W}, 32'd3);
            chk("nom_port", {16'd0, port_A, port_W},
                {16'd0, 8'(i + 1), 8'(i + 1)});
            chk("nom_no_fire", {31'd0, mac_start}, 32'd0);
        end
        chk("nom_full_ready", {30'd0, a_ready, w_ready}, 32'd0);
        a_valid = 1'b0; w_valid = 1'b0;
        step();
        chk("nom_fire", {31'd0, mac_start}, 32'd1);
        chk("nom_we_low", {30'd0, write_enable_A, write_enable_W}, 32'd0);
        chk("nom_port_hold", {16'd0, port_A, port_W}, 32'h1010);
        step();
        chk("nom_wait_ms", {31'd0, mac_start}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wait_start_busy", {31'd0, busy}, 32'd1);
        chk("wait_start_pulses", {29'd0, loader_rst, mac_start, done}, 32'd0);
        step();
        chk("wait_hold_done", {31'd0, done}, 32'd0);
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        chk("nom_done", {31'd0, done}, 32'd1);
        step();
        chk("nom_idle", {30'd0, busy, done}, 32'd0);
        chk("nom_counts", {n_wa[7:0], n_ww[7:0], n_ms[7:0], n_done[7:0]},
            32'h10100101);
        chk("nom_lr_count", n_lr, 32'd1);

        // Skewed: weights first, features with gaps
        clr_mon();
        begin_job();
        w_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_data = 8'(8'h40 + i);
            step();
        end
        chk("skew_w_port", {24'd0, port_W}, 32'h4f);
        chk("skew_w17_ready", {31'd0, w_ready}, 32'd0);
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        chk("load_macdone_ign", {30'd0, done, busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b1; a_data = 8'(8'h80 + i);
            step();
            a_valid = 1'b0;
            chk("skew_a_port", {23'd0, write_enable_A, port_A},
                {23'd0, 1'b1, 8'(8'h80 + i)});
            step();
            chk("skew_fire", {31'd0, mac_start}, (i == 15) ? 32'd1 : 32'd0);
        end
        w_valid = 1'b0;
        step();
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        chk("skew_done", {31'd0, done}, 32'd1);
        step();
        chk("skew_counts", {n_wa[7:0], n_ww[7:0], n_ms[7:0], n_done[7:0]},
            32'h10100101);

        // Overrun on the feature channel
        clr_mon();
        begin_job();
        a_valid = 1'b1; a_data = 8'h55;
        for (int i = 0; i < 20; i++) step();
        a_valid = 1'b0;
        chk("ovr_ready", {31'd0, a_ready}, 32'd0);
        chk("ovr_we_count", n_wa, 32'd16);
        chk("ovr_no_fire", n_ms, 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ovr_abort_idle", {31'd0, busy}, 32'd0);

        // Abort after 5 bytes, then restart
        clr_mon();
        begin_job();
        a_valid = 1'b1; w_valid = 1'b1; a_data = 8'h11; w_data = 8'h22;
        for (int i = 0; i < 5; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0; a_valid = 1'b0; w_valid = 1'b0;
        chk("abort_idle", {30'd0, busy, write_enable_A}, 32'd0);
        step(); step();
        chk("abort_counts", {n_wa[7:0], n_ww[7:0], n_ms[7:0], n_done[7:0]},
            32'h05050000);
        clr_mon();
        begin_job();
        a_valid = 1'b1; w_valid = 1'b1;
        for (int i = 0; i < 17; i++) step();
        a_valid = 1'b0; w_valid = 1'b0;
        chk("restart_fire", {31'd0, mac_start}, 32'd1);
        chk("restart_counts", {n_wa[7:0], n_ww[7:0], n_lr[7:0]}, 32'h101001);
        step();

        // Reset while in WAIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("wrst_outs", {24'd0, loader_rst, write_enable_A, write_enable_W,
            mac_start, done, a_ready, w_ready, busy}, 32'd0);
        chk("wrst_ports", {16'd0, port_A, port_W}, 32'd0);
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        step();
        chk("wrst_no_done", {30'd0, busy, done}, 32'd0);
        chk("wrst_done_count", n_done, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
